// File: rtl/hydro_pipe_sched.sv
// hydro_pipe_sched: windowed round-robin scheduler feeding N hydrophone channels into one timestamped pipeline.
// Optional HYDRO_FIRST_ARRIVAL_EN adds per-channel first-arrival timestamps (first_ts/first_vld).
module hydro_pipe_sched #(
  parameter int N = 4,
  parameter int W = 16,
  parameter int TSW = 32,
  parameter int WINDOW = 1024,
  localparam int CW = (N > 1) ? $clog2(N) : 1,
  localparam int WCW = $clog2(WINDOW)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic [N-1:0]     ch_valid,
  input  logic [N*W-1:0]   ch_data,
  output logic [N-1:0]     ch_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CW-1:0]    out_ch,
  output logic [TSW-1:0]   out_ts,
  output logic             busy,
  output logic             done
`ifdef HYDRO_FIRST_ARRIVAL_EN
  ,
  output logic [N*TSW-1:0] first_ts,
  output logic [N-1:0]     first_vld
`endif
);
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [WCW-1:0] win_q, win_d;
  logic [TSW-1:0] ts_q, ts_d;
  logic [CW-1:0] ptr_q, ptr_d, g, ix;
  logic out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [CW-1:0] out_ch_q, out_ch_d;
  logic [TSW-1:0] out_ts_q, out_ts_d;
  logic found, xfer, start;
  // Scan downward so the channel closest to the pointer wins.
  always_comb begin
    g = '0;
    found = 1'b0;
    ix = '0;
    for (int k = N - 1; k >= 0; k--) begin
      ix = CW'((int'(ptr_q) + k) % N);
      if (ch_valid[ix]) begin
        g = ix;
        found = 1'b1;
      end
    end
  end
  assign start = (state_q == IDLE) && arm;
  assign xfer = (state_q == CAPTURE) && (!out_valid_q || out_ready) && found;
  assign ch_ready = xfer ? (N'(1) << g) : '0;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm) state_d = CAPTURE;
      CAPTURE: if (win_q == '0) state_d = DRAIN;
      DRAIN:   if (!out_valid_q || out_ready) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    win_d = start ? WCW'(WINDOW - 1) : (state_q == CAPTURE && win_q != '0) ? win_q - 1'b1 : win_q;
    ts_d = start ? '0 : (state_q == CAPTURE) ? ts_q + 1'b1 : ts_q;
    ptr_d = xfer ? ((g == CW'(N - 1)) ? '0 : g + 1'b1) : ptr_q;
    out_valid_d = xfer || (out_valid_q && !out_ready);
    out_data_d = xfer ? W'(ch_data >> (int'(g) * W)) : out_data_q;
    out_ch_d = xfer ? g : out_ch_q;
    out_ts_d = xfer ? ts_q : out_ts_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q <= '0;
      ts_q <= '0;
      ptr_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q <= '0;
      out_ch_q <= '0;
      out_ts_q <= '0;
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      ts_q <= ts_d;
      ptr_q <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q <= out_data_d;
      out_ch_q <= out_ch_d;
      out_ts_q <= out_ts_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data = out_data_q;
  assign out_ch = out_ch_q;
  assign out_ts = out_ts_q;
  assign busy = (state_q == CAPTURE) || (state_q == DRAIN);
  assign done = state_q == DONE;
`ifdef HYDRO_FIRST_ARRIVAL_EN
  logic [N*TSW-1:0] first_ts_q, first_ts_d;
  logic [N-1:0] first_vld_q, first_vld_d;
  always_comb begin
    first_ts_d = first_ts_q;
    first_vld_d = start ? '0 : first_vld_q;
    for (int i = 0; i < N; i++) begin
      if (xfer && g == CW'(i) && !first_vld_q[i]) begin
        first_vld_d[i] = 1'b1;
        first_ts_d[i*TSW +: TSW] = ts_q;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_ts_q <= '0;
      first_vld_q <= '0;
    end else begin
      first_ts_q <= first_ts_d;
      first_vld_q <= first_vld_d;
    end
  end
  assign first_ts = first_ts_q;
  assign first_vld = first_vld_q;
`endif
endmodule

// File: doc/hydro_pipe_sched.md
HYDRO_PIPE_SCHED -- requirements
Module: hydro_pipe_sched

Interface
REQ-001 Parameter N, default 4: number of hydrophone channels sharing the conditioning/filtering/timestamping path.
REQ-002 Parameter W, default 16: per-channel sample width.
REQ-003 Parameter TSW, default 32: timestamp width.
REQ-004 Parameter WINDOW, default 1024: capture window length in clock cycles; legal range ≥2.
REQ-005 clk  in  1  system clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 arm  in  1  single-cycle pulse that starts a capture window.
REQ-008 ch_valid  in  N  per-channel sample available.
REQ-009 ch_data  in  N*W  per-channel samples; channel i occupies bits [i*W +: W].
REQ-010 ch_ready  out  N  one-hot (or zero) grant; a sample transfers when ch_valid[i] & ch_ready[i].
REQ-011 out_valid  out  1  sample held for the shared pipeline.
REQ-012 out_ready  in  1  shared pipeline accepts the sample.
REQ-013 out_data  out  W  granted sample.
REQ-014 out_ch  out  max(1,$clog2(N))  source channel index of out_data.
REQ-015 out_ts  out  TSW  timestamp of the cycle in which the sample was accepted.
REQ-016 busy  out  1  high in CAPTURE and DRAIN.
REQ-017 done  out  1  single-cycle pulse on window completion.

Function
REQ-018 FSM states: IDLE, CAPTURE, DRAIN, DONE.
REQ-019 IDLE→CAPTURE on arm; arm is ignored in every other state.
REQ-020 On entering CAPTURE: window counter loads WINDOW-1, ts_cnt clears to 0, and the round-robin pointer is preserved.
REQ-021 In CAPTURE: ts_cnt increments every cycle, wrapping modulo 2^TSW; the window counter decrements each cycle; CAPTURE→DRAIN in the cycle after the counter reads 0, giving exactly WINDOW grant-eligible cycles.
REQ-022 DRAIN→DONE when out_valid is 0 or out_valid & out_ready; DONE→IDLE unconditionally after one cycle; done is high only in DONE.
REQ-023 Grant rule: ch_ready is nonzero only in CAPTURE and only when the output register is empty or out_ready=1 in the same cycle.
REQ-024 Arbitration: round-robin starting at the pointer; exactly one requesting channel is granted; ch_ready is combinational from ch_valid and state.
REQ-025 On a transfer from channel g: the pointer becomes (g+1) mod N; out_data, out_ch and out_ts capture ch_data[g], g and the current ts_cnt, visible the next cycle.
REQ-026 out_valid sets on a transfer, clears on out_valid & out_ready without a new transfer, and stays 1 on a simultaneous consume and transfer (zero-bubble, one sample per cycle).
REQ-027 While out_valid=1 and out_ready=0, out_data, out_ch and out_ts hold stable.
REQ-028 Latency: sample accepted in cycle t appears on out_* in cycle t+1.
REQ-029 No ch_valid in CAPTURE: no grant; the pointer and output register are unchanged.

Reset
REQ-030 rst_n low immediately forces state=IDLE, ch_ready=0, out_valid=0, out_data=0, out_ch=0, out_ts=0, busy=0, done=0, pointer=0, ts_cnt=0 and window counter=0.
REQ-031 A reset asserted mid-window discards any held sample; after release the block waits in IDLE for arm.

Configuration
REQ-032 Macro HYDRO_FIRST_ARRIVAL_EN, when defined, adds output first_ts (N*TSW) and first_vld (N).
REQ-033 With HYDRO_FIRST_ARRIVAL_EN: first_vld clears on entering CAPTURE; on the first transfer from channel i in a window, first_ts[i] latches ts_cnt and first_vld[i] sets; later transfers leave both unchanged; reset clears both to 0.
REQ-034 Without HYDRO_FIRST_ARRIVAL_EN: these ports and registers do not exist; all other behaviour is identical.

Verification
REQ-035 N=4, WINDOW=8, arm, all ch_valid=1, out_ready=1 → grants in order 0,1,2,3,0,1,2,3; out_ts 0..7; done exactly once, 10 cycles after the arm cycle.
REQ-036 out_ready=0 for 5 cycles with out_valid=1 → ch_ready=0 and out_* stable; on out_ready=1, the next grant goes to the next channel in round-robin order.
REQ-037 Only channel 2 valid → ch2 granted every cycle; out_ch=2 throughout; pointer=3 after each transfer.
REQ-038 arm pulsed during CAPTURE → no effect on window length or ts_cnt.
REQ-039 rst_n low at window cycle 4 with out_valid=1 → all outputs 0 asynchronously; no done pulse; a new arm restarts with ts 0.
REQ-040 HYDRO_FIRST_ARRIVAL_EN, ch1 first valid at ts 3 and again at ts 6 → first_ts[1]=3, first_vld[1]=1; other channels' first_vld=0.
